deser_8_way: RTL and testbench

Serial-to-parallel collector: accepts one bit per cycle on a valid/ready input and packs eight accepted bits into an 8-bit word. The word is presented on a valid/ready output together with a registered "any bit set" flag. It is the widening counterpart of the 8-way OR reduction. It sits between bit-serial sources (debounced switch samplers, serial test stimulus) and the 8-bit datapath in the counter test design.

---
 rtl/deser_8_way.sv | 84 ++++++++
 tb/tb_deser_8_way.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/deser_8_way.sv
// Serial-to-parallel collector: packs eight accepted bits (MSB first) into a
// byte presented on a valid/ready output with a registered any-bit-set flag.
module deser_8_way (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       flush,
    output logic [7:0] out,
    output logic       out_any,
    output logic       out_valid,
    input  logic       out_ready
);

    logic [6:0] sr_q, sr_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] out_q, out_d;
    logic       any_q, any_d;
    logic       valid_q, valid_d;

    logic       accept;
    logic       handshake;
    logic       word_done;
    logic [7:0] word;

    // Only the eighth bit can stall, and only behind an undelivered word.
    assign in_ready  = !((cnt_q == 3'd7) && valid_q && !out_ready);
    assign accept    = in_valid && in_ready && !flush;
    assign handshake = valid_q && out_ready;
    assign word_done = accept && (cnt_q == 3'd7);
    assign word      = {sr_q, in_bit};

    // Next-state: shift/count, word load, output handshake and flush.
    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        any_d   = any_q;
        valid_d = valid_q;

        if (flush) begin
            cnt_d = 3'd0;
        end else if (accept) begin
            if (cnt_q == 3'd7) begin
                out_d = word;
                any_d = |word;
                cnt_d = 3'd0;
            end else begin
                sr_d  = {sr_q[5:0], in_bit};
                cnt_d = cnt_q + 3'd1;
            end
        end

        // A new word landing in the handshake cycle keeps valid high.
        if (word_done) begin
            valid_d = 1'b1;
        end else if (handshake) begin
            valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q    <= 7'd0;
            cnt_q   <= 3'd0;
            out_q   <= 8'h00;
            any_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            any_q   <= any_d;
            valid_q <= valid_d;
        end
    end

    assign out       = out_q;
    assign out_any   = any_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_deser_8_way.sv
// Self-checking bench for deser_8_way: arithmetic reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_deser_8_way;

    logic       clk;
    logic       rst_n;
    logic       in_bit;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic [7:0] out;
    logic       out_any;
    logic       out_valid;
    logic       out_ready;

    int total = 0;
    int bad   = 0;

    deser_8_way dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out       (out),
        .out_any   (out_any),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: bits held so far as a count plus an integer value.
    int   m_n;
    int   m_acc;
    int   m_word;
    logic m_vld;

    logic exp_ready;
    logic m_take;
    assign exp_ready = !(m_n == 7 && m_vld && !out_ready);
    assign m_take    = in_valid && exp_ready && !flush;

    // Model update on the same edges as the design.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n    <= 0;
            m_acc  <= 0;
            m_word <= 0;
            m_vld  <= 1'b0;
        end else begin
            if (flush) begin
                m_n   <= 0;
                m_acc <= 0;
            end else if (m_take) begin
                if (m_n == 7) begin
                    m_word <= (m_acc * 2 + int'(in_bit)) % 256;
                    m_n    <= 0;
                    m_acc  <= 0;
                end else begin
                    m_acc <= m_acc * 2 + int'(in_bit);
                    m_n   <= m_n + 1;
                end
            end
            if (m_take && m_n == 7) m_vld <= 1'b1;
            else if (m_vld && out_ready) m_vld <= 1'b0;
        end
    end

    // Compare process: every falling edge out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if (in_ready !== exp_ready) begin
                bad++;
                $display("FAIL model_in_ready t=%0t got=%b exp=%b", $time, in_ready, exp_ready);
            end
            total++;
            if (out_valid !== m_vld) begin
                bad++;
                $display("FAIL model_out_valid t=%0t got=%b exp=%b", $time, out_valid, m_vld);
            end
            if (m_vld) begin
                total++;
                if (out !== m_word[7:0] || out_any !== (m_word != 0)) begin
                    bad++;
                    $display("FAIL model_out t=%0t got=%h/%b exp=%h/%b", $time, out, out_any,
                             m_word[7:0], (m_word != 0));
                end
            end
        end
    end

    task automatic lit(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            in_bit   = w[i];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    int vcnt;
    int vfirst;
    int vsecond;
    logic [7:0] stream;
    logic [15:0] pair;

    initial begin
        rst_n     = 1'b0;
        in_bit    = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #12;
        lit("reset_out", out, 8'h00);
        lit("reset_any", {7'd0, out_any}, 8'd0);
        lit("reset_valid", {7'd0, out_valid}, 8'd0);
        lit("reset_ready", {7'd0, in_ready}, 8'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Stream B2 with out_ready high: one-cycle valid pulse.
        out_ready = 1'b1;
        stream = 8'hB2;
        send_word(stream);
        lit("b2_valid", {7'd0, out_valid}, 8'd1);
        lit("b2_out", out, 8'hB2);
        lit("b2_any", {7'd0, out_any}, 8'd1);
        tick();
        lit("b2_valid_drop", {7'd0, out_valid}, 8'd0);
        lit("b2_out_hold", out, 8'hB2);

        // Eight zeros, held undelivered.
        out_ready = 1'b0;
        send_word(8'h00);
        lit("zero_valid", {7'd0, out_valid}, 8'd1);
        lit("zero_out", out, 8'h00);
        lit("zero_any", {7'd0, out_any}, 8'd0);
        out_ready = 1'b1;
        tick();
        lit("zero_taken", {7'd0, out_valid}, 8'd0);

        // Back-to-back FF then 01.
        pair = 16'hFF01;
        vcnt = 0; vfirst = -1; vsecond = -1;
        for (int i = 0; i < 17; i++) begin
            in_valid = (i < 16);
            in_bit   = (i < 16) ? pair[15 - i] : 1'b0;
            if (in_ready !== 1'b1) lit("b2b_ready", {7'd0, in_ready}, 8'd1);
            tick();
            if (out_valid) begin
                vcnt++;
                if (vfirst < 0) vfirst = i; else vsecond = i;
            end
            if (i == 7) lit("b2b_ff", out, 8'hFF);
            if (i == 15) lit("b2b_01", out, 8'h01);
        end
        in_valid = 1'b0;
        lit("b2b_pulses", vcnt[7:0], 8'd2);
        lit("b2b_first", vfirst[7:0], 8'd7);
        lit("b2b_gap", 8'(vsecond - vfirst), 8'd8);

        // Backpressure: A=5A stalled, B=C3 eighth bit refused then accepted.
        out_ready = 1'b0;
        send_word(8'h5A);
        lit("a_out", out, 8'h5A);
        stream = 8'hC3;
        for (int i = 7; i >= 1; i--) begin
            in_bit = stream[i]; in_valid = 1'b1;
            lit("b_early_ready", {7'd0, in_ready}, 8'd1);
            tick();
        end
        in_bit = stream[0]; in_valid = 1'b1;
        lit("b8_refused", {7'd0, in_ready}, 8'd0);
        tick();
        lit("a_held", out, 8'h5A);
        lit("a_held_valid", {7'd0, out_valid}, 8'd1);
        lit("b8_still_refused", {7'd0, in_ready}, 8'd0);
        out_ready = 1'b1;
        #1;
        lit("b8_ready_comb", {7'd0, in_ready}, 8'd1);
        tick();
        in_valid = 1'b0;
        lit("b_out", out, 8'hC3);
        lit("b_valid", {7'd0, out_valid}, 8'd1);
        tick();
        lit("b_taken", {7'd0, out_valid}, 8'd0);

        // Flush discards three bits and the bit offered during flush.
        for (int i = 0; i < 3; i++) begin
            in_bit = 1'b1; in_valid = 1'b1; tick();
        end
        flush = 1'b1; in_bit = 1'b1; in_valid = 1'b1;
        tick();
        flush = 1'b0;
        send_word(8'h81);
        lit("flush_out", out, 8'h81);
        lit("flush_valid", {7'd0, out_valid}, 8'd1);
        tick();

        // Asynchronous reset mid-word, after a word is already held.
        out_ready = 1'b0;
        send_word(8'hE7);
        for (int i = 0; i < 5; i++) begin
            in_bit = 1'b1; in_valid = 1'b1; tick();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        lit("arst_out", out, 8'h00);
        lit("arst_valid", {7'd0, out_valid}, 8'd0);
        lit("arst_any", {7'd0, out_any}, 8'd0);
        lit("arst_ready", {7'd0, in_ready}, 8'd1);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        send_word(8'h3C);
        lit("post_rst_out", out, 8'h3C);
        lit("post_rst_valid", {7'd0, out_valid}, 8'd1);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
